// File: rtl/shift_reg_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | shift_reg_pkg: shared mode encoding and defaults for the shift register |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package shift_reg_pkg;

  localparam int SR_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    LOAD = 2'd1,
    SHL  = 2'd2,
    SHR  = 2'd3
  } shift_mode_e;

endpackage : shift_reg_pkg
`default_nettype wire

// File: rtl/shift_mode_decode.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | shift_mode_decode: priority encoder from control levels to a mode     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module shift_mode_decode
  import shift_reg_pkg::*;
(
  input  logic        load,
  input  logic        shift_left,
  input  logic        shift_right,
  output shift_mode_e mode
);

  // Conflicting shift requests fall through to HOLD rather than picking a side.
  always_comb begin
    mode = HOLD;
    if (load)
      mode = LOAD;
    else if (shift_left && !shift_right)
      mode = SHL;
    else if (shift_right && !shift_left)
      mode = SHR;
  end

endmodule : shift_mode_decode
`default_nettype wire

// File: rtl/universal_shift_reg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | universal_shift_reg: parallel-load, bidirectional shift/rotate register |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module universal_shift_reg
  import shift_reg_pkg::*;
#(
  parameter int   WIDTH  = SR_DEFAULT_WIDTH,
  parameter int   ROTATE = 0,
  parameter logic FILL   = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift_left,
  input  logic             shift_right,
  input  logic [WIDTH-1:0] parallel_in,
  output logic [WIDTH-1:0] q
);

  generate
    if (WIDTH < 2) begin : g_width_check
      $error("universal_shift_reg: WIDTH must be at least 2");
    end
  endgenerate

  shift_mode_e      mode;
  logic             in_l;
  logic             in_r;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  shift_mode_decode u_decode (
    .load        (load),
    .shift_left  (shift_left),
    .shift_right (shift_right),
    .mode        (mode)
  );

  generate
    if (ROTATE != 0) begin : g_rotate
      assign in_l = data_q[WIDTH-1];
      assign in_r = data_q[0];
    end else begin : g_fill
      assign in_l = FILL;
      assign in_r = FILL;
    end
  endgenerate

  always_comb begin
    data_d = data_q;
    case (mode)
      LOAD:    data_d = parallel_in;
      SHL:     data_d = {data_q[WIDTH-2:0], in_l};
      SHR:     data_d = {in_r, data_q[WIDTH-1:1]};
      default: data_d = data_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset)
      data_q <= '0;
    else
      data_q <= data_d;
  end

  assign q = data_q;

endmodule : universal_shift_reg
`default_nettype wire

// File: tb/tb_universal_shift_reg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_universal_shift_reg: directed checks of fill, rotate and priority  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_universal_shift_reg;

  logic       clk;
  logic       reset;
  logic       load;
  logic       shift_left;
  logic       shift_right;
  logic [7:0] parallel_in;
  logic [7:0] q;
  logic [7:0] q_fill;
  logic [7:0] q_rot;

  int tests;
  int fails;

  universal_shift_reg #(.WIDTH(8), .ROTATE(0), .FILL(1'b0)) dut (
    .clk(clk), .reset(reset), .load(load), .shift_left(shift_left),
    .shift_right(shift_right), .parallel_in(parallel_in), .q(q)
  );

  universal_shift_reg #(.WIDTH(8), .ROTATE(0), .FILL(1'b1)) dut_fill (
    .clk(clk), .reset(reset), .load(load), .shift_left(shift_left),
    .shift_right(shift_right), .parallel_in(parallel_in), .q(q_fill)
  );

  universal_shift_reg #(.WIDTH(8), .ROTATE(1), .FILL(1'b0)) dut_rot (
    .clk(clk), .reset(reset), .load(load), .shift_left(shift_left),
    .shift_right(shift_right), .parallel_in(parallel_in), .q(q_rot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic ld, input logic sl,
                       input logic sr, input logic [7:0] pin);
    reset       = r;
    load        = ld;
    shift_left  = sl;
    shift_right = sr;
    parallel_in = pin;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    tests++;
    if (q !== 8'h00) begin
      fails++;
      $display("FAIL reset: q=%h expected %h", q, 8'h00);
    end
    tests++;
    if (q_fill !== 8'h00) begin
      fails++;
      $display("FAIL reset_fill: q=%h expected %h", q_fill, 8'h00);
    end
    tests++;
    if (q_rot !== 8'h00) begin
      fails++;
      $display("FAIL reset_rot: q=%h expected %h", q_rot, 8'h00);
    end
  endtask

  task automatic test_load_shift();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'b10101010);
    tick();
    tests++;
    if (q !== 8'hAA) begin
      fails++;
      $display("FAIL load_aa: q=%h expected %h", q, 8'hAA);
    end
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    tick();
    tests++;
    if (q !== 8'h54) begin
      fails++;
      $display("FAIL shl_fill0: q=%h expected %h", q, 8'h54);
    end
    tests++;
    if (q_fill !== 8'h55) begin
      fails++;
      $display("FAIL shl_fill1: q=%h expected %h", q_fill, 8'h55);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    tick();
    tests++;
    if (q !== 8'h2A) begin
      fails++;
      $display("FAIL shr_fill0: q=%h expected %h", q, 8'h2A);
    end
    tests++;
    if (q_fill !== 8'hAA) begin
      fails++;
      $display("FAIL shr_fill1: q=%h expected %h", q_fill, 8'hAA);
    end
  endtask

  task automatic test_reset_priority();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'hAA);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'hFF);
    tick();
    tests++;
    if (q !== 8'h00) begin
      fails++;
      $display("FAIL reset_over_load: q=%h expected %h", q, 8'h00);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h3C);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    tick();
    tests++;
    if (q_fill !== 8'h00) begin
      fails++;
      $display("FAIL reset_over_shift: q=%h expected %h", q_fill, 8'h00);
    end
  endtask

  task automatic test_load_priority();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h81);
    tick();
    tests++;
    if (q !== 8'h81) begin
      fails++;
      $display("FAIL load_over_shl: q=%h expected %h", q, 8'h81);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h42);
    tick();
    tests++;
    if (q !== 8'h42) begin
      fails++;
      $display("FAIL load_over_shr: q=%h expected %h", q, 8'h42);
    end
  endtask

  task automatic test_hold();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h3C);
    tick();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 8'hFF);
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (q !== 8'h3C) begin
        fails++;
        $display("FAIL hold_both_%0d: q=%h expected %h", i, q, 8'h3C);
      end
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF);
    for (int i = 0; i < 2; i++) begin
      tick();
      tests++;
      if (q !== 8'h3C) begin
        fails++;
        $display("FAIL hold_idle_%0d: q=%h expected %h", i, q, 8'h3C);
      end
    end
  endtask

  task automatic test_walk();
    logic [7:0] one;
    logic [7:0] exp;
    one = 8'h01;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h01);
    tick();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp = one << k;
      tests++;
      if (q !== exp) begin
        fails++;
        $display("FAIL walk_%0d: q=%h expected %h", k, q, exp);
      end
    end
  endtask

  task automatic test_rotate();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h81);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    tick();
    tests++;
    if (q_rot !== 8'hC0) begin
      fails++;
      $display("FAIL rot_right: q=%h expected %h", q_rot, 8'hC0);
    end
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    tick();
    tests++;
    if (q_rot !== 8'h81) begin
      fails++;
      $display("FAIL rot_left: q=%h expected %h", q_rot, 8'h81);
    end
    tick();
    tests++;
    if (q_rot !== 8'h03) begin
      fails++;
      $display("FAIL rot_left_wrap: q=%h expected %h", q_rot, 8'h03);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    test_reset();
    test_load_shift();
    test_reset_priority();
    test_load_priority();
    test_hold();
    test_walk();
    test_rotate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_universal_shift_reg
`default_nettype wire

// File: doc/universal_shift_reg.md
# universal_shift_reg

Parallel-load, bidirectional shift register with a single parallel output. It serves as a general-purpose data staging and serialisation element inside datapath blocks. Each clock edge either loads a parallel word, shifts the contents one bit left or right, or holds them. The register is parameterised for width and for the shift fill policy.

## Interface

Parameters:
- `WIDTH`, default 8: register width in bits; must be at least 2.
- `ROTATE`, default 0: 0 = logical shift with fill; 1 = rotate, so the bit shifted out re-enters at the opposite end.
- `FILL`, default 1'b0: bit inserted at the vacated end when `ROTATE` = 0.

Ports:
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `reset`, input, 1: synchronous, active-low reset; sampled on the rising edge of `clk`.
- `load`, input, 1: parallel load request.
- `shift_left`, input, 1: shift toward the MSB by one bit.
- `shift_right`, input, 1: shift toward the LSB by one bit.
- `parallel_in`, input, WIDTH: data word for a load.
- `q`, output, WIDTH: register contents, driven directly from flops.

## Operation

- On each rising `clk` edge, exactly one action applies, evaluated in this priority order:
  1. `reset` = 0: `q` <= 0.
  2. `load` = 1: `q` <= `parallel_in`.
  3. `shift_left` = 1 and `shift_right` = 0: `q` <= {`q`[WIDTH-2:0], `in_l`}.
     - `in_l` = `q`[WIDTH-1] when `ROTATE` = 1, otherwise `FILL`.
  4. `shift_right` = 1 and `shift_left` = 0: `q` <= {`in_r`, `q`[WIDTH-1:1]}.
     - `in_r` = `q`[0] when `ROTATE` = 1, otherwise `FILL`.
  5. Otherwise hold, including when `shift_left` = `shift_right` = 1.
- `load` overrides both shift controls, so `parallel_in` is captured unshifted.
- `reset` overrides everything. Asserting reset mid-sequence clears the register on that edge and discards any pending load or shift.
- No serial output port; the shifted-out bit is visible as `q[WIDTH-1]` or `q[0]` before the edge.
- Inputs are level-sensitive and sampled on every edge. Holding a shift control high for N edges shifts N positions.

## Timing

- Latency: `q` reflects the action one edge after the controls are sampled. There is no combinational path from any input to `q`.
- Reset value: `q` = {WIDTH{1'b0}}, valid after the first edge with `reset` low.
- Before the first reset, `q` is undefined; no power-on initial value is required.
- No handshake; every edge accepts new control inputs.
- No internal state machine beyond the WIDTH data flops.

## Structure

- Shared package `shift_reg_pkg`:
  - mode enum `shift_mode_e` = {HOLD, LOAD, SHL, SHR};
  - default width constant `SR_DEFAULT_WIDTH` = 8.
- Control decode is a purely combinational priority encoder producing `shift_mode_e`. Implement it as sub-module `shift_mode_decode`, with inputs `load`, `shift_left`, `shift_right` and output mode.
- The top level holds the register and a next-state mux driven by the decoded mode, plus parameter checks: elaboration error if `WIDTH` < 2.

## Test plan

Default parameters (`WIDTH` = 8, `ROTATE` = 0, `FILL` = 0) unless noted:
- Reset, then `load` = 1 with `parallel_in` = 8'b10101010 for one edge -> `q` = 8'hAA. Next: `shift_left` for one edge -> 8'h54. Next: `shift_right` for one edge -> 8'h2A.
- `q` = 8'hAA, then `reset` = 0 for one edge with `load` = 1 and `parallel_in` = 8'hFF -> `q` = 8'h00 (reset wins).
- `load` = 1, `shift_left` = 1, `parallel_in` = 8'h81 -> `q` = 8'h81 (load wins, no shift).
- `q` = 8'h3C, `shift_left` = `shift_right` = 1 for 3 edges -> `q` stays 8'h3C. Then all controls low for 2 edges -> `q` still 8'h3C.
- Load 8'h01, hold `shift_left` for 8 edges -> `q` walks 8'h02 ... 8'h80, then 8'h00.
- With `ROTATE` = 1: load 8'h81, then `shift_right` one edge -> 8'hC0, then `shift_left` one edge -> 8'h81.
